// File: rtl/crc_pkg.sv
// crc_pkg: shared definitions for the serial CRC engine and its CAN destuffer.
//   crc_state_t     - engine FSM state encoding
//   CAN_CRC15_POLY  - CAN CRC-15 generator polynomial (x^15 term implicit)
//   CAN_CRC15_INIT  - CAN CRC-15 start value
//   CAN_STUFF_LEN   - run length of equal bits after which a stuff bit follows
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DATA     = 2'd1,
    ST_TX_SHIFT = 2'd2,
    ST_RX_CRC   = 2'd3
  } crc_state_t;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
  localparam logic [14:0] CAN_CRC15_INIT = 15'h0000;
  localparam int unsigned CAN_STUFF_LEN  = 5;

endpackage

// File: rtl/can_destuff.sv
// can_destuff: in-line CAN bit destuffer (only built with CRC_DESTUFF_EN).
// Tracks the previous bit and the current run length. Once STUFF_LEN equal
// bits have been seen, the next strobed bit is a stuff bit: it is not passed
// on, and the run restarts at 1 with its value. A stuff bit equal to the
// previous bit is a violation.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   clear       - restart run tracking (new frame)
//   din         - serial bit
//   din_valid   - strobe qualifying din (already gated by the caller)
//   absorb      - din is a data bit and should be absorbed (combinational)
//   stuff_err   - din is a stuff bit with the wrong polarity (combinational)
`ifdef CRC_DESTUFF_EN
module can_destuff #(
  parameter int unsigned STUFF_LEN = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic din,
  input  logic din_valid,
  output logic absorb,
  output logic stuff_err
);

  localparam int unsigned RUN_W = $clog2(STUFF_LEN + 1);

  logic             prev_q;
  logic [RUN_W-1:0] run_q;
  logic             stuff_slot;

  assign stuff_slot = (run_q == RUN_W'(STUFF_LEN));
  assign absorb     = din_valid && !stuff_slot;
  assign stuff_err  = din_valid && stuff_slot && (din == prev_q);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      run_q  <= '0;
      prev_q <= 1'b0;
    end else if (din_valid) begin
      // A stuff bit, the first bit, or a polarity change all start a new run.
      if (stuff_slot || (run_q == '0) || (din != prev_q)) begin
        run_q <= RUN_W'(1);
      end else begin
        run_q <= run_q + RUN_W'(1);
      end
      prev_q <= din;
    end
  end

endmodule
`endif

// File: rtl/crc_serial_engine.sv
// crc_serial_engine: parametrised bit-serial CRC engine (CAN TX/RX datapath).
// Absorbs data bits on din_valid strobes, then either shifts the CRC out
// MSB-first (transmit, check_mode=0) or absorbs the received CRC field and
// reports crc_ok (receive, check_mode=1).
//
// Optional feature macro: CRC_DESTUFF_EN -- in-line CAN destuffing of din in
// DATA and RX_CRC; stuff violations pulse stuff_err and drop to IDLE.
// Without it every strobed bit is absorbed and stuff_err is tied 0.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - begin new frame (aborts any frame in progress)
//   check_mode      - sampled with start: 0 transmit, 1 receive
//   din, din_valid  - serial data bit and its one-cycle strobe
//   last            - with din_valid: final data bit of the frame
//   crc_bit         - serial CRC output, MSB first
//   crc_bit_valid   - crc_bit is valid
//   crc_bit_ready   - consumer accepts crc_bit
//   crc             - live CRC register
//   busy            - engine is not idle
//   done            - one-cycle end-of-frame pulse
//   crc_ok          - receive result, valid with done, held until next start
//   stuff_err       - one-cycle stuff violation pulse
//
// Handshake: a CRC bit transfers on every rising clk edge where
// crc_bit_valid && crc_bit_ready; crc_bit stays stable while valid is high
// and ready is low; ready without valid has no effect.
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(CAN_CRC15_POLY),
  parameter logic [CRC_W-1:0] INIT  = CRC_W'(CAN_CRC15_INIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             check_mode,
  input  logic             din,
  input  logic             din_valid,
  input  logic             last,
  output logic             crc_bit,
  output logic             crc_bit_valid,
  input  logic             crc_bit_ready,
  output logic [CRC_W-1:0] crc,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             stuff_err
);

  crc_state_t       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             serr_q, serr_d;

  logic             bit_strobe;
  logic             absorb;
  logic             stuff_viol;
  logic [CRC_W-1:0] crc_step_v;
  logic             last_cnt;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic             b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  // start has priority over a coincident data strobe, so mask it here.
  assign bit_strobe = din_valid && !start &&
                      ((state_q == ST_DATA) || (state_q == ST_RX_CRC));

`ifdef CRC_DESTUFF_EN
  can_destuff #(
    .STUFF_LEN (CAN_STUFF_LEN)
  ) u_destuff (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .din       (din),
    .din_valid (bit_strobe),
    .absorb    (absorb),
    .stuff_err (stuff_viol)
  );
`else
  assign absorb     = bit_strobe;
  assign stuff_viol = 1'b0;
`endif

  assign crc_step_v = crc_step(crc_q, din);
  assign last_cnt   = (cnt_q == 6'(CRC_W - 1));

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    serr_d  = 1'b0;
    if (start) begin
      state_d = ST_DATA;
      crc_d   = INIT;
      cnt_d   = '0;
      mode_d  = check_mode;
      ok_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_DATA: begin
          if (stuff_viol) begin
            state_d = ST_IDLE;
            serr_d  = 1'b1;
          end else if (absorb) begin
            crc_d = crc_step_v;
            if (last) begin
              state_d = mode_q ? ST_RX_CRC : ST_TX_SHIFT;
              cnt_d   = '0;
            end
          end
        end
        ST_TX_SHIFT: begin
          if (crc_bit_ready) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0};
            cnt_d = cnt_q + 6'd1;
            if (last_cnt) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        ST_RX_CRC: begin
          if (stuff_viol) begin
            state_d = ST_IDLE;
            serr_d  = 1'b1;
          end else if (absorb) begin
            crc_d = crc_step_v;
            cnt_d = cnt_q + 6'd1;
            if (last_cnt) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              // Message followed by its own CRC leaves a zero remainder.
              ok_d    = (crc_step_v == '0);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      serr_q  <= serr_d;
    end
  end

  assign crc_bit_valid = (state_q == ST_TX_SHIFT);
  assign crc_bit       = crc_bit_valid ? crc_q[CRC_W-1] : 1'b0;
  assign crc           = crc_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign crc_ok        = ok_q;
  assign stuff_err     = serr_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: self-checking bench for crc_serial_engine (default
// CAN CRC-15 parameters). Reference CRC is computed by textbook polynomial
// long division of the message (with CRC_W appended zeros) by the generator.
// With CRC_DESTUFF_EN defined the driver inserts CAN stuff bits and the
// destuffing cases are exercised.
module tb_crc_serial_engine;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, check_mode, din, din_valid, last;
  logic         crc_bit, crc_bit_valid, crc_bit_ready;
  logic [W-1:0] crc;
  logic         busy, done, crc_ok, stuff_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic prev_b;
  int   run_n;

  crc_serial_engine dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .check_mode    (check_mode),
    .din           (din),
    .din_valid     (din_valid),
    .last          (last),
    .crc_bit       (crc_bit),
    .crc_bit_valid (crc_bit_valid),
    .crc_bit_ready (crc_bit_ready),
    .crc           (crc),
    .busy          (busy),
    .done          (done),
    .crc_ok        (crc_ok),
    .stuff_err     (stuff_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference: remainder of msg(x) * x^W divided by the generator polynomial.
  function automatic logic [W-1:0] model_crc(input bit msg[$]);
    bit d[$];
    logic [W:0]   g;
    logic [W-1:0] r;
    g = {1'b1, 15'h4599};
    d = msg;
    for (int k = 0; k < W; k++) d.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (d[i]) for (int j = 0; j <= W; j++) d[i+j] = d[i+j] ^ g[W-j];
    r = '0;
    for (int j = 0; j < W; j++) r = {r[W-2:0], d[msg.size()+j]};
    return r;
  endfunction

  task automatic push_bits(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back({31'd0, v[i]});
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic mode);
    start = 1'b1; check_mode = mode;
    tick();
    start = 1'b0; check_mode = $urandom_range(0, 1);
    prev_b = 1'b0; run_n = 0;
  endtask

  task automatic send_raw(input logic b, input logic l);
    din = b; din_valid = 1'b1; last = l;
    tick();
    din_valid = 1'b0; last = 1'b0; din = $urandom_range(0, 1);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      din = $urandom_range(0, 1);
      tick();
    end
  endtask

  // Sends a frame bit; inserts a stuff bit first when the destuffer expects one.
  task automatic send_bit(input logic b, input logic l);
`ifdef CRC_DESTUFF_EN
    if (run_n == 5) begin
      gap();
      send_raw(!prev_b, 1'b0);
      prev_b = !prev_b; run_n = 1;
    end
    if (run_n == 0 || b != prev_b) begin prev_b = b; run_n = 1; end
    else run_n++;
`endif
    gap();
    send_raw(b, l);
  endtask

  task automatic send_msg(input bit msg[$]);
    for (int i = 0; i < msg.size(); i++) send_bit(msg[i], i == msg.size() - 1);
  endtask

  // Drains exp_q through the handshake; mode 0 ready=1, 1 toggling, 2 random.
  task automatic tx_drain(input string tag, input int mode, output int hs);
    int guard;
    logic r;
    hs = 0; guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
      crc_bit_ready = r;
      if (crc_bit_valid && r) begin
        chk({tag, "_bit"}, {31'd0, crc_bit}, exp_q.pop_front());
        hs++;
      end else if (crc_bit_valid) begin
        chk({tag, "_stall_bit"}, {31'd0, crc_bit}, exp_q[0]);
      end
      tick();
      guard++;
    end
    crc_bit_ready = 1'b0;
    chk({tag, "_drain_timeout"}, exp_q.size(), 0);
    exp_q.delete();
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_busy_low"}, {31'd0, busy}, 0);
    chk({tag, "_valid_low"}, {31'd0, crc_bit_valid}, 0);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  task automatic rx_frame(input string tag, input bit msg[$], input logic [W-1:0] rx_crc,
                          input logic exp_ok);
    do_start(1'b1);
    send_msg(msg);
    chk({tag, "_rx_crc_after_data"}, {17'd0, crc}, {17'd0, model_crc(msg)});
    for (int i = W - 1; i >= 0; i--) begin
      chk({tag, "_no_early_done"}, {31'd0, done}, 0);
      send_bit(rx_crc[i], 1'b0);
    end
    chk({tag, "_rx_done"}, {31'd0, done}, 1);
    chk({tag, "_rx_busy"}, {31'd0, busy}, 0);
    chk({tag, "_rx_ok"}, {31'd0, crc_ok}, {31'd0, exp_ok});
    tick();
    chk({tag, "_rx_done_pulse"}, {31'd0, done}, 0);
    chk({tag, "_rx_ok_held"}, {31'd0, crc_ok}, {31'd0, exp_ok});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit msg[$];
    int hs;
    logic [W-1:0] m, rc;
    logic [W-1:0] golden;
    int len, pos;
    logic corrupt;

    rst = 1'b1; start = 0; check_mode = 0; din = 0; din_valid = 0; last = 0;
    crc_bit_ready = 0; prev_b = 0; run_n = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_crc", {17'd0, crc}, 0);
    chk("rst_crc_bit", {31'd0, crc_bit}, 0);
    chk("rst_valid", {31'd0, crc_bit_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ok", {31'd0, crc_ok}, 0);
    chk("rst_stuff_err", {31'd0, stuff_err}, 0);

    // IDLE ignores data strobes
    send_raw(1'b1, 1'b0);
    send_raw(1'b1, 1'b1);
    chk("idle_ignore_crc", {17'd0, crc}, 0);
    chk("idle_ignore_busy", {31'd0, busy}, 0);

    // single bit 1 -> 0x4599, serial stream 100010110011001
    do_start(1'b0);
    chk("t1_busy", {31'd0, busy}, 1);
    send_raw(1'b1, 1'b1);
    chk("t1_crc", {17'd0, crc}, 32'h4599);
    chk("t1_valid_rise", {31'd0, crc_bit_valid}, 1);
    golden = 15'b100010110011001;
    push_bits(golden);
    tx_drain("t1", 0, hs);
    chk("t1_handshakes", hs, 15);

    // bits 1,0 -> 0x4EAB with toggling ready
    do_start(1'b0);
    send_raw(1'b1, 1'b0);
    send_raw(1'b0, 1'b1);
    chk("t2_crc", {17'd0, crc}, 32'h4EAB);
    golden = 15'h4EAB;
    push_bits(golden);
    tx_drain("t2", 1, hs);
    chk("t2_handshakes", hs, 15);

    // receive: bit 1 then CRC 0x4599 (good), then one corrupted bit
    msg = {1'b1};
    rx_frame("t3_good", msg, 15'h4599, 1'b1);
    pos = $urandom_range(0, W - 1);
    rc = 15'h4599;
    rc[pos] = ~rc[pos];
    rx_frame("t3_bad", msg, rc, 1'b0);

    // abort mid TX_SHIFT after 7 bits; coincident data strobe must be dropped
    do_start(1'b0);
    send_raw(1'b1, 1'b1);
    crc_bit_ready = 1'b1;
    repeat (7) tick();
    chk("t4_still_busy", {31'd0, busy}, 1);
    start = 1'b1; check_mode = 1'b0; din = 1'b1; din_valid = 1'b1; last = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b0; last = 1'b0; crc_bit_ready = 1'b0;
    prev_b = 0; run_n = 0;
    chk("t4_crc_init", {17'd0, crc}, 0);
    chk("t4_no_done", {31'd0, done}, 0);
    chk("t4_busy", {31'd0, busy}, 1);
    chk("t4_valid_low", {31'd0, crc_bit_valid}, 0);
    send_raw(1'b1, 1'b0);
    send_raw(1'b0, 1'b1);
    chk("t4_crc", {17'd0, crc}, 32'h4EAB);
    golden = 15'h4EAB;
    push_bits(golden);
    tx_drain("t4", 2, hs);

    // reset while in RX_CRC
    do_start(1'b1);
    send_raw(1'b1, 1'b1);
    send_raw(1'b1, 1'b0);
    send_raw(1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_crc", {17'd0, crc}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_done", {31'd0, done}, 0);
    chk("t5_ok", {31'd0, crc_ok}, 0);
    chk("t5_valid", {31'd0, crc_bit_valid}, 0);
    chk("t5_crc_bit", {31'd0, crc_bit}, 0);
    chk("t5_stuff_err", {31'd0, stuff_err}, 0);
    repeat (4) send_raw(1'b1, 1'b0);
    chk("t5_ignored_crc", {17'd0, crc}, 0);
    chk("t5_ignored_busy", {31'd0, busy}, 0);

`ifdef CRC_DESTUFF_EN
    // 1,1,1,1,1,(stuff 0),1 -> same CRC as six ones
    do_start(1'b0);
    repeat (5) send_raw(1'b1, 1'b0);
    send_raw(1'b0, 1'b1);
    chk("t6_stuff_not_last", {31'd0, busy && !crc_bit_valid}, 1);
    send_raw(1'b1, 1'b1);
    msg = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    chk("t6_crc", {17'd0, crc}, {17'd0, model_crc(msg)});
    push_bits(model_crc(msg));
    tx_drain("t6", 0, hs);
    // sixth equal bit -> stuff_err
    do_start(1'b0);
    repeat (5) send_raw(1'b1, 1'b0);
    send_raw(1'b1, 1'b0);
    chk("t6_stuff_err", {31'd0, stuff_err}, 1);
    chk("t6_err_busy", {31'd0, busy}, 0);
    chk("t6_err_no_done", {31'd0, done}, 0);
    tick();
    chk("t6_err_pulse", {31'd0, stuff_err}, 0);
`endif

    // randomized frames against the division model
    for (int f = 0; f < 24; f++) begin
      msg.delete();
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) msg.push_back(1'($urandom_range(0, 1)));
      m = model_crc(msg);
      if ($urandom_range(0, 1) == 0) begin
        do_start(1'b0);
        send_msg(msg);
        chk("rnd_tx_crc", {17'd0, crc}, {17'd0, m});
        chk("rnd_tx_valid", {31'd0, crc_bit_valid}, 1);
        push_bits(m);
        tx_drain("rnd_tx", 2, hs);
      end else begin
        corrupt = 1'($urandom_range(0, 1));
        rc = m;
        if (corrupt) begin
          pos = $urandom_range(0, W - 1);
          rc[pos] = ~rc[pos];
        end
        rx_frame("rnd_rx", msg, rc, !corrupt);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_serial_engine.md
# crc_serial_engine

Parametrised bit-serial CRC engine for the CAN controller datapath, generalising the fixed CRC-15 LFSR to any width, polynomial and initial value. Absorbs data bits at bit-sample strobes, then either shifts the computed CRC out MSB-first under a valid/ready handshake (transmit) or absorbs the received CRC field and reports pass/fail (receive). Sits between the bit-timing/sampling logic and the frame FSMs of both TX and RX paths.

## Interface
- CRC_W, 15: CRC width in bits (2..32)
- POLY, 15'h4599: generator polynomial, implicit x^CRC_W term omitted
- INIT, 0: register value loaded on start
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse: load INIT, begin new frame; sample check_mode
- check_mode  in  1  0 = transmit (generate), 1 = receive (check)
- din  in  1  serial data bit
- din_valid  in  1  one-cycle strobe qualifying din
- last  in  1  qualifies din_valid: final data bit of the frame
- crc_bit  out  1  serial CRC output, MSB first
- crc_bit_valid  out  1  crc_bit is valid
- crc_bit_ready  in  1  consumer accepts crc_bit
- crc  out  CRC_W  live register contents
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of frame
- crc_ok  out  1  receive result, valid with done, held until next start
- stuff_err  out  1  one-cycle pulse on stuff violation (0 without macro)

## Operation
- Update per absorbed bit: fb = crc[CRC_W-1] ^ din; crc <= {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0). No final XOR.
- States: IDLE, DATA, TX_SHIFT, RX_CRC.
- IDLE: ignores din_valid. start -> DATA, crc <= INIT, crc_ok <= 0, mode latched.
- DATA: each absorbed bit updates crc. Absorbed bit with last=1 -> TX_SHIFT (mode 0) or RX_CRC (mode 1); bit counter cleared.
- TX_SHIFT: crc_bit = crc[CRC_W-1], crc_bit_valid = 1. On valid&ready: crc shifts left, zero-fill, counter++. After CRC_W-th handshake -> IDLE, done pulses.
- RX_CRC: next CRC_W absorbed bits update crc as in DATA. After CRC_W-th -> IDLE, done pulses, crc_ok = (crc next value == 0).
- start in any state: aborts and restarts (crc <= INIT, counters/run cleared); no done for the aborted frame.
- start and din_valid in the same cycle: start wins, bit discarded.
- rst: all state cleared regardless of state.

## Timing
- Reset values: crc = INIT, crc_bit = 0, crc_bit_valid = 0, busy = 0, done = 0, crc_ok = 0, stuff_err = 0.
- crc reflects an absorbed bit one cycle after its din_valid.
- crc_bit_valid rises the cycle after the last data bit is absorbed; back-to-back handshakes sustain one bit per cycle; ready without valid is ignored.
- done asserts the cycle after the final CRC bit is handshaked (TX) or sampled (RX); busy falls the same cycle.
- din_valid may arrive every cycle; no minimum spacing.

## Configuration
- CRC_DESTUFF_EN defined: in-line CAN destuffing on din. Tracks previous bit and run length (reset at start). After 5 equal bits, the next din_valid bit is a stuff bit: not absorbed, last ignored, run restarts at 1 with its value. If that bit equals the previous, stuff_err pulses, done does not, state -> IDLE. Applies in DATA and RX_CRC; TX_SHIFT output is not stuffed (framer's job).
- Undefined: every din_valid bit absorbed; stuff_err tied 0; no run-length logic.

## Structure
- Package crc_pkg: state enum, CAN_CRC15_POLY = 15'h4599, CAN_CRC15_INIT = 0, CAN_STUFF_LEN = 5.
- Sub-module can_destuff (under CRC_DESTUFF_EN): din/din_valid in, absorb strobe and stuff_err out.

## Test plan
- start mode 0, single bit 1 with last -> crc = 0x4599; with ready=1 the serial stream is 100010110011001, then done.
- Bits 1,0 (last on 2nd) -> crc = 0x4EAB; ready toggling 1/0 -> exactly 15 handshakes, bits unchanged by stalls.
- Mode 1: bit 1 then received CRC 0x4599 -> done, crc_ok = 1; corrupt any CRC bit -> crc_ok = 0.
- start mid-TX_SHIFT after 7 bits -> no done, crc = INIT, new frame computes correctly.
- CRC_DESTUFF_EN: 1,1,1,1,1,0(stuff),1 last -> stuff excluded, crc equals undestuffed 1,1,1,1,1,1 result; 6th equal bit -> stuff_err pulse, busy = 0.
- rst asserted in RX_CRC -> next cycle all outputs at reset values, subsequent din_valid ignored.
